// File: rtl/coupler_run_arbiter_pkg.sv
// Shared types for the coupler run arbiter: FSM state encoding and the
// reserved end-of-run fill bit.
package coupler_run_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Terminator is the all-zero element; TERM_BIT is replicated to P_WIDTH.
    localparam logic TERM_BIT = 1'b0;

endpackage

// File: rtl/coupler_run_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr+1 (mod N_IN),
// via rotate, isolate lowest set bit, rotate back.
module rr_picker #(
    parameter int unsigned N_IN  = 4,
    localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic [N_IN-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_IN-1:0]  o_grant,
    output logic             o_valid
);

    logic [PTR_W-1:0] start;
    logic [N_IN-1:0]  rot;
    logic [N_IN-1:0]  pri;

    always_comb begin
        start = (i_ptr == PTR_W'(N_IN - 1)) ? '0 : i_ptr + PTR_W'(1);
        rot   = N_IN'({i_req, i_req} >> start);
        pri   = rot & (~rot + N_IN'(1));
        // Upper copy of the doubled vector holds the un-rotated grant.
        o_grant = N_IN'(({pri, pri} << start) >> N_IN);
        o_valid = |i_req;
    end

endmodule

// File: rtl/coupler_run_arbiter.sv
// Round-robin run scheduler feeding one coupler input from N_IN leaf streams,
// forwarding whole zero-terminated runs and capping run length at MAX_RUN.
module coupler_run_arbiter
    import coupler_run_arbiter_pkg::*;
#(
    parameter int unsigned P_WIDTH = 128,
    parameter int unsigned N_IN    = 4,
    parameter int unsigned MAX_RUN = 1024,
    localparam int unsigned CNT_W  = $clog2(MAX_RUN + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [N_IN*P_WIDTH-1:0] i_data,
    input  logic [N_IN-1:0]         i_empty,
    output logic [N_IN-1:0]         o_deq,
    output logic [P_WIDTH-1:0]      o_data,
    output logic                    o_enq,
    input  logic                    i_full,
    output logic [N_IN-1:0]         o_grant,
    output logic                    o_busy,
    output logic                    o_run_done,
    output logic [CNT_W-1:0]        o_last_len,
    output logic                    o_overrun
);

    localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [P_WIDTH-1:0] TERM = {P_WIDTH{TERM_BIT}};

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] g_idx;
    logic [CNT_W-1:0] run_cnt;

    logic [N_IN-1:0]    req;
    logic [N_IN-1:0]    pick_grant;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [P_WIDTH-1:0] head;
    logic               streaming;
    logic               at_max;
    logic               inject;
    logic               xfer;

    assign req = ~i_empty;

    rr_picker #(
        .N_IN (N_IN)
    ) u_picker (
        .i_req   (req),
        .i_ptr   (ptr),
        .o_grant (pick_grant),
        .o_valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (pick_grant[k]) pick_idx = PTR_W'(k);
        end
    end

    // Head of the granted stream only; ungranted data never reaches o_data.
    always_comb begin
        head = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (g_idx == PTR_W'(k)) head = i_data[k*P_WIDTH +: P_WIDTH];
        end
    end

    always_comb begin
        streaming = (state == ST_STREAM);
        at_max    = (run_cnt == CNT_W'(MAX_RUN));
        inject    = streaming & at_max & ~i_full;
        xfer      = streaming & ~at_max & ~i_empty[g_idx] & ~i_full;

        o_enq  = ~i_rst & (inject | xfer);
        o_deq  = (~i_rst & xfer) ? o_grant : '0;
        o_data = '0;
        if (~i_rst & inject) begin
            o_data = TERM;
        end else if (~i_rst & xfer) begin
            o_data = head;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            ptr        <= PTR_W'(N_IN - 1);
            g_idx      <= '0;
            run_cnt    <= '0;
            o_grant    <= '0;
            o_busy     <= 1'b0;
            o_run_done <= 1'b0;
            o_last_len <= '0;
            o_overrun  <= 1'b0;
        end else begin
            o_run_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_en && pick_valid) begin
                        o_grant <= pick_grant;
                        g_idx   <= pick_idx;
                        o_busy  <= 1'b1;
                        state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (inject) begin
                        o_overrun  <= 1'b1;
                        o_last_len <= CNT_W'(MAX_RUN);
                        o_run_done <= 1'b1;
                        run_cnt    <= '0;
                        o_grant    <= '0;
                        o_busy     <= 1'b0;
                        state      <= ST_GAP;
                    end else if (xfer) begin
                        if (head == TERM) begin
                            o_last_len <= run_cnt;
                            o_run_done <= 1'b1;
                            run_cnt    <= '0;
                            o_grant    <= '0;
                            o_busy     <= 1'b0;
                            state      <= ST_GAP;
                        end else begin
                            run_cnt <= run_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    ptr   <= g_idx;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coupler_run_arbiter.sv
// Directed bench for coupler_run_arbiter with a queue model of the leaf FIFOs.
module tb_coupler_run_arbiter;

    localparam int unsigned PW = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned MR = 4;
    localparam int unsigned CW = $clog2(MR + 1);

    typedef logic [PW-1:0] elem_t;

    typedef struct {
        int            cyc;
        elem_t         data;
        logic [N-1:0]  deq;
        logic [N-1:0]  grant;
    } ev_t;

    typedef struct {
        logic          full;
        logic          enq;
        logic [N-1:0]  deq;
        elem_t         data;
        logic [N-1:0]  grant;
        logic          busy;
        logic          done;
        logic [CW-1:0] len;
    } vec_t;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_en;
    logic [N*PW-1:0] i_data;
    logic [N-1:0]    i_empty;
    logic [N-1:0]    o_deq;
    elem_t           o_data;
    logic            o_enq;
    logic            i_full;
    logic [N-1:0]    o_grant;
    logic            o_busy;
    logic            o_run_done;
    logic [CW-1:0]   o_last_len;
    logic            o_overrun;

    always #5 i_clk = ~i_clk;

    coupler_run_arbiter #(
        .P_WIDTH (PW),
        .N_IN    (N),
        .MAX_RUN (MR)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_data     (i_data),
        .i_empty    (i_empty),
        .o_deq      (o_deq),
        .o_data     (o_data),
        .o_enq      (o_enq),
        .i_full     (i_full),
        .o_grant    (o_grant),
        .o_busy     (o_busy),
        .o_run_done (o_run_done),
        .o_last_len (o_last_len),
        .o_overrun  (o_overrun)
    );

    elem_t fifo [N][$];
    ev_t   ev_q [$];
    vec_t  vt [11];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;

    logic          cap_enq, cap_busy, cap_done, cap_ovr;
    logic [N-1:0]  cap_deq, cap_grant;
    elem_t         cap_data;
    logic [CW-1:0] cap_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Empty leaves present garbage so any leak into o_data is visible.
    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            i_empty[k] = (fifo[k].size() == 0);
            i_data[k*PW +: PW] = (fifo[k].size() == 0) ? 32'hDEAD_BEEF : fifo[k][0];
        end
    endtask

    task automatic clear_fifos();
        for (int k = 0; k < N; k++) fifo[k].delete();
    endtask

    task automatic tick();
        @(negedge i_clk);
        cap_enq = o_enq; cap_deq = o_deq; cap_data = o_data; cap_grant = o_grant;
        cap_busy = o_busy; cap_done = o_run_done; cap_len = o_last_len; cap_ovr = o_overrun;
        if (cap_enq) ev_q.push_back('{cyc: cyc, data: cap_data, deq: cap_deq, grant: cap_grant});
        cyc++;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (cap_deq[k] && fifo[k].size() != 0) void'(fifo[k].pop_front());
        end
        refresh();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_fifos();
        refresh();
        tick();
        tick();
    endtask

    task automatic run_until(input int n_ev, input int budget, input string name);
        int k = 0;
        while (ev_q.size() < n_ev && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(ev_q.size() >= n_ev), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state and single run with backpressure (table-driven) ----
        i_rst = 1'b1; i_en = 1'b1; i_full = 1'b0;
        clear_fifos();
        fifo[0].push_back(5); fifo[0].push_back(7); fifo[0].push_back(9); fifo[0].push_back(0);
        refresh();
        tick();
        tick();
        chk("rst_grant", 64'(cap_grant), 0);
        chk("rst_busy", 64'(cap_busy), 0);
        chk("rst_enq", 64'(cap_enq), 0);
        chk("rst_deq", 64'(cap_deq), 0);
        chk("rst_data", 64'(cap_data), 0);
        chk("rst_done", 64'(cap_done), 0);
        chk("rst_len", 64'(cap_len), 0);
        chk("rst_ovr", 64'(cap_ovr), 0);

        vt[0]  = '{1'b0, 1'b0, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 3'd0};
        vt[1]  = '{1'b0, 1'b1, 4'b0001, 5, 4'b0001, 1'b1, 1'b0, 3'd0};
        vt[2]  = '{1'b1, 1'b0, 4'b0000, 0, 4'b0001, 1'b1, 1'b0, 3'd0};
        vt[3]  = '{1'b1, 1'b0, 4'b0000, 0, 4'b0001, 1'b1, 1'b0, 3'd0};
        vt[4]  = '{1'b1, 1'b0, 4'b0000, 0, 4'b0001, 1'b1, 1'b0, 3'd0};
        vt[5]  = '{1'b0, 1'b1, 4'b0001, 7, 4'b0001, 1'b1, 1'b0, 3'd0};
        vt[6]  = '{1'b0, 1'b1, 4'b0001, 9, 4'b0001, 1'b1, 1'b0, 3'd0};
        vt[7]  = '{1'b0, 1'b1, 4'b0001, 0, 4'b0001, 1'b1, 1'b0, 3'd0};
        vt[8]  = '{1'b0, 1'b0, 4'b0000, 0, 4'b0000, 1'b0, 1'b1, 3'd3};
        vt[9]  = '{1'b0, 1'b0, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 3'd3};
        vt[10] = '{1'b0, 1'b0, 4'b0000, 0, 4'b0000, 1'b0, 1'b0, 3'd3};

        i_rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            i_full = vt[i].full;
            tick();
            chk($sformatf("vec%0d_enq", i), 64'(cap_enq), 64'(vt[i].enq));
            chk($sformatf("vec%0d_deq", i), 64'(cap_deq), 64'(vt[i].deq));
            chk($sformatf("vec%0d_data", i), 64'(cap_data), 64'(vt[i].data));
            chk($sformatf("vec%0d_grant", i), 64'(cap_grant), 64'(vt[i].grant));
            chk($sformatf("vec%0d_busy", i), 64'(cap_busy), 64'(vt[i].busy));
            chk($sformatf("vec%0d_done", i), 64'(cap_done), 64'(vt[i].done));
            chk($sformatf("vec%0d_len", i), 64'(cap_len), 64'(vt[i].len));
        end
        i_full = 1'b0;

        // ---- round-robin over four {1,0} runs ----
        do_reset();
        for (int k = 0; k < N; k++) begin
            fifo[k].push_back(1);
            fifo[k].push_back(0);
        end
        refresh();
        ev_q.delete();
        i_rst = 1'b0;
        run_until(8, 60, "rr_budget");
        for (int i = 0; i < 8 && i < ev_q.size(); i++) begin
            chk($sformatf("rr%0d_data", i), 64'(ev_q[i].data), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr%0d_grant", i), 64'(ev_q[i].grant), 64'(1 << (i / 2)));
            chk($sformatf("rr%0d_deq", i), 64'(ev_q[i].deq), 64'(1 << (i / 2)));
            if (i > 0) begin
                chk($sformatf("rr%0d_gap", i), 64'(ev_q[i].cyc - ev_q[i-1].cyc),
                    (i % 2 == 1) ? 64'd1 : 64'd3);
            end
        end

        // ---- overrun with MAX_RUN = 4 on stream 1 ----
        do_reset();
        for (int v = 1; v <= 6; v++) fifo[1].push_back(elem_t'(v));
        refresh();
        ev_q.delete();
        i_rst = 1'b0;
        run_until(7, 60, "ovr_budget");
        tick();
        tick();
        if (ev_q.size() >= 7) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ovr%0d_data", i), 64'(ev_q[i].data), 64'(i + 1));
                chk($sformatf("ovr%0d_deq", i), 64'(ev_q[i].deq), 64'b0010);
            end
            chk("ovr_inj_data", 64'(ev_q[4].data), 0);
            chk("ovr_inj_deq", 64'(ev_q[4].deq), 0);
            chk("ovr_inj_adj", 64'(ev_q[4].cyc - ev_q[3].cyc), 1);
            chk("ovr_regrant_gap", 64'(ev_q[5].cyc - ev_q[4].cyc), 3);
            chk("ovr_res5_data", 64'(ev_q[5].data), 5);
            chk("ovr_res6_data", 64'(ev_q[6].data), 6);
            chk("ovr_res_grant", 64'(ev_q[5].grant), 64'b0010);
            chk("ovr_res_deq", 64'(ev_q[6].deq), 64'b0010);
        end
        chk("ovr_flag", 64'(cap_ovr), 1);
        chk("ovr_len", 64'(cap_len), 4);
        chk("ovr_stall_busy", 64'(cap_busy), 1);
        chk("ovr_stall_enq", 64'(cap_enq), 0);
        fifo[1].push_back(0);
        refresh();
        run_until(8, 20, "ovr_term_budget");
        tick();
        tick();
        if (ev_q.size() >= 8) begin
            chk("ovr_term_data", 64'(ev_q[7].data), 0);
            chk("ovr_term_deq", 64'(ev_q[7].deq), 64'b0010);
        end
        chk("ovr_len2", 64'(cap_len), 2);
        chk("ovr_sticky", 64'(cap_ovr), 1);

        // ---- i_en gating ----
        do_reset();
        i_en = 1'b0;
        fifo[2].push_back(3); fifo[2].push_back(0);
        fifo[3].push_back(4); fifo[3].push_back(0);
        refresh();
        ev_q.delete();
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("en_off_events", 64'(ev_q.size()), 0);
        chk("en_off_grant", 64'(cap_grant), 0);
        i_en = 1'b1;
        tick();
        i_en = 1'b0;
        run_until(2, 20, "en_drop_budget");
        for (int i = 0; i < 6; i++) tick();
        chk("en_drop_events", 64'(ev_q.size()), 2);
        if (ev_q.size() >= 2) begin
            chk("en_drop_grant", 64'(ev_q[0].grant), 64'b0100);
            chk("en_drop_term", 64'(ev_q[1].data), 0);
        end
        chk("en_drop_idle_grant", 64'(cap_grant), 0);
        chk("en_drop_idle_busy", 64'(cap_busy), 0);
        chk("en_drop_len", 64'(cap_len), 1);
        i_en = 1'b1;

        // ---- asynchronous reset mid-stream, then priority restored ----
        do_reset();
        fifo[0].push_back(1); fifo[0].push_back(0);
        fifo[1].push_back(2); fifo[1].push_back(3); fifo[1].push_back(0);
        refresh();
        ev_q.delete();
        i_rst = 1'b0;
        run_until(3, 30, "arst_budget");
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_grant", 64'(o_grant), 0);
        chk("arst_busy", 64'(o_busy), 0);
        chk("arst_enq", 64'(o_enq), 0);
        chk("arst_deq", 64'(o_deq), 0);
        chk("arst_data", 64'(o_data), 0);
        chk("arst_len", 64'(o_last_len), 0);
        clear_fifos();
        fifo[0].push_back(6); fifo[0].push_back(0);
        fifo[1].push_back(7); fifo[1].push_back(0);
        refresh();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        ev_q.delete();
        run_until(1, 20, "arst_rel_budget");
        if (ev_q.size() >= 1) begin
            chk("arst_prio_grant", 64'(ev_q[0].grant), 64'b0001);
            chk("arst_prio_data", 64'(ev_q[0].data), 6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
